debounce_scan_scheduler: RTL and testbench

- Time-multiplexes one debounce/edge-detect engine across NCH noisy inputs (buttons/switches).
- A round-robin scan pointer visits one channel per clock.
- Per channel: conditioned level and one-cycle edge pulses, matching the single-channel input conditioner semantics.
- Edge events are also queued in a small FIFO with a valid/ready handshake for a downstream consumer (UI/FSM).

---
 rtl/debounce_scan_scheduler.sv | 119 +++++++++++
 tb/tb_debounce_scan_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan_scheduler.sv
// debounce_scan_scheduler: one time-shared debounce/edge engine scanning NCH inputs, with an event FIFO
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   noisysignal[NCH]     raw asynchronous inputs
//   conditioned[NCH]     debounced level per channel
//   positiveedge[NCH]    one-clock pulse on conditioned 0->1
//   negativeedge[NCH]    one-clock pulse on conditioned 1->0
//   scanchannel[CHW]     channel evaluated this cycle
//   evvalid/evready      event FIFO handshake (head shown on evchannel/evrising)
//   evoverflow           sticky dropped-event flag, cleared by overflowclear
module debounce_scan_scheduler #(
    parameter int NCH       = 4,
    parameter int CHW       = 2,
    parameter int WAITTIME  = 3,
    parameter int CNTW      = 3,
    parameter int FIFODEPTH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [NCH-1:0] noisysignal,
    output logic [NCH-1:0] conditioned,
    output logic [NCH-1:0] positiveedge,
    output logic [NCH-1:0] negativeedge,
    output logic [CHW-1:0] scanchannel,
    output logic           evvalid,
    input  logic           evready,
    output logic [CHW-1:0] evchannel,
    output logic           evrising,
    output logic           evoverflow,
    input  logic           overflowclear
);
    localparam int AW = $clog2(FIFODEPTH);
    localparam int EW = CHW + 1;

    logic [NCH-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NCH-1:0]  cond_q, cond_d, pos_q, pos_d, neg_q, neg_d;
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic [CHW-1:0]  scan_q, scan_d;
    logic [EW-1:0]   mem_q [FIFODEPTH];
    logic [EW-1:0]   mem_d [FIFODEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            accept, full, pop, push;

    always_comb begin
        sync1_d = noisysignal;
        sync2_d = sync1_q;
        scan_d  = scan_q + CHW'(1);
        cnt_d   = cnt_q;
        cond_d  = cond_q;
        pos_d   = '0;
        neg_d   = '0;
        accept  = 1'b0;
        // only the scanned channel is evaluated; all others hold
        if (sync2_q[scan_q] == cond_q[scan_q]) begin
            cnt_d[scan_q] = '0;
        end else if (cnt_q[scan_q] == CNTW'(WAITTIME - 1)) begin
            cnt_d[scan_q]  = '0;
            cond_d[scan_q] = sync2_q[scan_q];
            pos_d[scan_q]  = sync2_q[scan_q];
            neg_d[scan_q]  = !sync2_q[scan_q];
            accept         = 1'b1;
        end else begin
            cnt_d[scan_q] = cnt_q[scan_q] + CNTW'(1);
        end
        full  = count_q == (AW+1)'(FIFODEPTH);
        pop   = (count_q != '0) && evready;
        // a simultaneous pop frees the slot, so a full FIFO still accepts
        push  = accept && (!full || pop);
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {scan_q, sync2_q[scan_q]};
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        // a fresh drop outranks a clear in the same cycle
        ovf_d   = (accept && !push) ? 1'b1 : (overflowclear ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cond_q  <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            cnt_q   <= '{default: '0};
            scan_q  <= '0;
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cond_q  <= cond_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign conditioned  = cond_q;
    assign positiveedge = pos_q;
    assign negativeedge = neg_q;
    assign scanchannel  = scan_q;
    assign evvalid      = count_q != '0;
    assign evchannel    = mem_q[rd_q][EW-1:1];
    assign evrising     = mem_q[rd_q][0];
    assign evoverflow   = ovf_q;
endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb_debounce_scan_scheduler: randomized + directed scoreboard bench for debounce_scan_scheduler
module tb_debounce_scan_scheduler;
    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int WT  = 3;
    localparam int FD  = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [NCH-1:0] noisy = '0;
    logic           evready = 1'b0;
    logic           ovclr = 1'b0;
    logic [NCH-1:0] conditioned, positiveedge, negativeedge;
    logic [CHW-1:0] scanchannel, evchannel;
    logic           evvalid, evrising, evoverflow;

    debounce_scan_scheduler #(.NCH(NCH), .CHW(CHW), .WAITTIME(WT), .CNTW(3), .FIFODEPTH(FD)) dut (
        .clk(clk), .resetn(resetn), .noisysignal(noisy),
        .conditioned(conditioned), .positiveedge(positiveedge), .negativeedge(negativeedge),
        .scanchannel(scanchannel), .evvalid(evvalid), .evready(evready),
        .evchannel(evchannel), .evrising(evrising), .evoverflow(evoverflow),
        .overflowclear(ovclr)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int r;} ev_t;

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int cyc = 0;
    int streak [NCH];
    int rise_cnt [NCH];
    int fall_cnt [NCH];
    int rise_tick [NCH];
    logic [NCH-1:0] m_s1, m_s2, m_cond, m_pos, m_neg;
    bit m_ovf, popped;
    ev_t sb [$];
    ev_t evlog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_s1 = '0; m_s2 = '0; m_cond = '0; m_pos = '0; m_neg = '0;
        m_ovf = 0; popped = 0; sb.delete();
        for (int k = 0; k < NCH; k++) streak[k] = 0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NCH; k++) begin
            rise_cnt[k] = 0; fall_cnt[k] = 0; rise_tick[k] = -1;
        end
    endtask

    // Channel k is looked at once every NCH clocks; WT consecutive looks that
    // disagree with the accepted level make the new level stick.
    task automatic model_edge();
        int k;
        bit drop;
        k = cyc % NCH;
        drop = 0;
        m_pos = '0; m_neg = '0;
        if (m_s2[k] != m_cond[k]) begin
            streak[k]++;
            if (streak[k] == WT) begin
                streak[k] = 0;
                m_cond[k] = m_s2[k];
                if (m_s2[k]) m_pos[k] = 1'b1; else m_neg[k] = 1'b1;
                if (sb.size() + int'(popped) < FD || popped) sb.push_back('{k, int'(m_s2[k])});
                else drop = 1;
            end
        end else streak[k] = 0;
        m_ovf = drop ? 1'b1 : (ovclr ? 1'b0 : m_ovf);
        popped = 0;
        m_s2 = m_s1;
        m_s1 = noisy;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        tick++;
        chk("conditioned", 32'(conditioned), 32'(m_cond));
        chk("posedge", 32'(positiveedge), 32'(m_pos));
        chk("negedge", 32'(negativeedge), 32'(m_neg));
        chk("scanchannel", 32'(scanchannel), 32'(cyc % NCH));
        chk("evoverflow", 32'(evoverflow), 32'(m_ovf));
        chk("edge_onehot", 32'($countones(positiveedge | negativeedge) <= 1), 32'd1);
        for (int k = 0; k < NCH; k++) begin
            if (positiveedge[k]) begin rise_cnt[k]++; rise_tick[k] = tick; end
            if (negativeedge[k]) fall_cnt[k]++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        resetn = 1'b0; noisy = '0; evready = 1'b0; ovclr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        clear_counts();
        resetn = 1'b1;
    endtask

    // Monitor: sample mid-cycle; a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (resetn) begin
            chk("evvalid", 32'(evvalid), 32'(sb.size() != 0));
            if (evvalid && evready && sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                chk("evchannel", 32'(evchannel), 32'(e.ch));
                chk("evrising", 32'(evrising), 32'(e.r));
                evlog.push_back('{int'(evchannel), int'(evrising)});
                popped = 1;
            end
        end
    end

    initial begin
        int t0;
        do_reset();
        chk("rst_cond", 32'(conditioned), 32'd0);
        chk("rst_edges", 32'(positiveedge | negativeedge), 32'd0);
        chk("rst_scan", 32'(scanchannel), 32'd0);
        chk("rst_valid", 32'(evvalid), 32'd0);
        chk("rst_ovf", 32'(evoverflow), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("scan_seq", 32'(scanchannel), 32'((i + 1) % NCH));
        end

        // ch2 rise and fall with consumer ready
        evready = 1'b1;
        noisy[2] = 1'b1;
        t0 = tick;
        steps(20);
        chk("lat2_range", 32'((rise_tick[2] - t0) >= 11 && (rise_tick[2] - t0) <= 14), 32'd1);
        chk("rise2_once", 32'(rise_cnt[2]), 32'd1);
        noisy[2] = 1'b0;
        steps(20);
        chk("fall2_once", 32'(fall_cnt[2]), 32'd1);

        // glitch on ch1: 6 clocks high is too short
        noisy[1] = 1'b1;
        steps(6);
        noisy[1] = 1'b0;
        steps(20);
        chk("glitch_rise", 32'(rise_cnt[1]), 32'd0);
        chk("glitch_cond", 32'(conditioned[1]), 32'd0);

        // overflow: 5 events into a 4-deep FIFO
        evready = 1'b0;
        noisy[0] = 1'b1; steps(20);
        noisy[1] = 1'b1; steps(20);
        noisy[0] = 1'b0; steps(20);
        noisy[1] = 1'b0; steps(20);
        noisy[3] = 1'b1; steps(20);
        chk("ovf_set", 32'(evoverflow), 32'd1);
        chk("cond3_after_drop", 32'(conditioned[3]), 32'd1);
        evlog.delete();
        evready = 1'b1;
        steps(8);
        chk("drain_n", 32'(evlog.size()), 32'd4);
        if (evlog.size() == 4) begin
            chk("drain0", 32'(evlog[0].ch * 2 + evlog[0].r), 32'd1);
            chk("drain1", 32'(evlog[1].ch * 2 + evlog[1].r), 32'd3);
            chk("drain2", 32'(evlog[2].ch * 2 + evlog[2].r), 32'd0);
            chk("drain3", 32'(evlog[3].ch * 2 + evlog[3].r), 32'd2);
        end
        ovclr = 1'b1; step(); ovclr = 1'b0;
        chk("ovf_clear", 32'(evoverflow), 32'd0);
        noisy[3] = 1'b0; steps(20);

        // simultaneous rise on ch0 and ch3, phased so ch0 is visited first
        clear_counts();
        for (int i = 0; i < 8 && scanchannel != 2; i++) step();
        evlog.delete();
        noisy[0] = 1'b1; noisy[3] = 1'b1;
        steps(20);
        chk("simul_gap", 32'(rise_tick[3] - rise_tick[0]), 32'd3);
        chk("simul_n", 32'(evlog.size()), 32'd2);
        if (evlog.size() == 2) begin
            chk("simul_first", 32'(evlog[0].ch), 32'd0);
            chk("simul_second", 32'(evlog[1].ch), 32'd3);
        end

        // async reset mid-count with two events queued
        evready = 1'b0;
        noisy[0] = 1'b0; noisy[3] = 1'b0;
        steps(20);
        chk("queued2", 32'(evvalid), 32'd1);
        noisy[2] = 1'b1;
        steps(6);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_cond", 32'(conditioned), 32'd0);
        chk("async_edges", 32'(positiveedge | negativeedge), 32'd0);
        chk("async_scan", 32'(scanchannel), 32'd0);
        chk("async_valid", 32'(evvalid), 32'd0);
        chk("async_ovf", 32'(evoverflow), 32'd0);
        do_reset();
        evready = 1'b1;
        steps(20);
        chk("post_rst_rise", 32'(rise_cnt[2] + fall_cnt[2]), 32'd0);
        chk("post_rst_valid", 32'(evvalid), 32'd0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) noisy[$urandom_range(NCH - 1)] ^= 1'b1;
            evready = ($urandom_range(3) != 0) && (i % 400 > 120);
            ovclr = ($urandom_range(15) == 0);
            step();
        end
        ovclr = 1'b0;
        evready = 1'b1;
        steps(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
